// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV immediate generator: format codes, opcodes
// and parameter legality checks.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ISH = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   function automatic bit xlen_legal(input int unsigned xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

   function automatic bit depth_legal(input int unsigned depth);
      return (depth >= 2) && (depth <= 8);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV immediate decoder: classifies the opcode and builds the
// XLEN-wide extended immediate.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_e            fmt_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        sign;
   logic        is_shift;
   logic        use_sext;
   logic [5:0]  shamt;
   logic [31:0] low;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign sign   = instr_i[31];

   // Shift-immediates take priority over the generic I format of OP-IMM.
   assign is_shift = ((opcode == OP_IMM) || (opcode == OP_IMM32)) &&
                     ((funct3 == F3_SLL) || (funct3 == F3_SRX));

   // RV32 shamt is 5 bits; bit 25 belongs to funct7 there.
   assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

   always_comb begin
      low      = '0;
      use_sext = 1'b0;
      fmt_o    = FMT_ILL;
      if (is_shift) begin
         fmt_o = FMT_ISH;
         low   = {26'b0, shamt};
      end else begin
         case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
               fmt_o    = FMT_I;
               use_sext = 1'b1;
               low      = {{20{sign}}, instr_i[31:20]};
            end
            OP_STORE: begin
               fmt_o    = FMT_S;
               use_sext = 1'b1;
               low      = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
               fmt_o    = FMT_B;
               use_sext = 1'b1;
               low      = {{19{sign}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               fmt_o    = FMT_U;
               use_sext = 1'b1;
               low      = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
               fmt_o    = FMT_J;
               use_sext = 1'b1;
               low      = {{11{sign}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_OP, OP_OP32: fmt_o = FMT_R;
            default:        fmt_o = FMT_ILL;
         endcase
      end
      imm_o       = {XLEN{sign & use_sext}};
      imm_o[31:0] = low;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decodes on accept, computes pc+imm and queues
// results in a small FIFO whose head is presented on registered outputs.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      fmt_o,
   output logic [XLEN-1:0] target_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (!depth_legal(DEPTH)) begin : g_bad_depth
      $error("imm_gen_pipe: DEPTH must be 2..8");
   end

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic [XLEN-1:0] dec_target;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr_i (instr_i),
      .imm_o   (dec_imm),
      .fmt_o   (dec_fmt)
   );

   assign dec_target = pc_i + dec_imm;

   logic [XLEN-1:0] imm_mem [DEPTH];
   fmt_e            fmt_mem [DEPTH];
   logic [XLEN-1:0] tgt_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   fmt_e             fmt_q, fmt_d;
   logic [XLEN-1:0]  target_q, target_d;

   logic push;
   logic pop;
   logic head_is_new;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push = in_valid_i & in_ready_q;
   assign pop  = out_valid_q & out_ready_i;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      imm_d       = imm_q;
      fmt_d       = fmt_q;
      target_d    = target_q;
      head_is_new = 1'b0;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
         // The incoming entry becomes the head when nothing older survives.
         head_is_new = push && (count_q == CNT_W'(pop));
      end
      out_valid_d = (count_d != '0);
      in_ready_d  = (count_d != CNT_W'(DEPTH));
      // With an empty buffer the outputs keep whatever they last showed.
      if (out_valid_d) begin
         if (head_is_new) begin
            imm_d    = dec_imm;
            fmt_d    = dec_fmt;
            target_d = dec_target;
         end else begin
            imm_d    = imm_mem[rd_ptr_d];
            fmt_d    = fmt_mem[rd_ptr_d];
            target_d = tgt_mem[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         imm_mem[wr_ptr_q] <= dec_imm;
         fmt_mem[wr_ptr_q] <= dec_fmt;
         tgt_mem[wr_ptr_q] <= dec_target;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         imm_q       <= '0;
         fmt_q       <= FMT_R;
         target_q    <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         imm_q       <= imm_d;
         fmt_q       <= fmt_d;
         target_q    <= target_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign imm_o       = imm_q;
   assign fmt_o       = fmt_q;
   assign target_o    = target_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32 (DEPTH 2) and an RV64 (DEPTH 4)
// instance, each checked against an arithmetic reference decoder.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] tgt;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [2:0]  fmt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   // Known-answer vectors; imm given at 64 bits and truncated for RV32.
   vec_t vecs [5] = '{
      '{32'hFE112E23, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd2},
      '{32'hFE000CE3, 64'h100,  64'hFFFF_FFFF_FFFF_FFF8, 3'd3},
      '{32'hFFDFF06F, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd5},
      '{32'h800000B7, 64'h0,    64'hFFFF_FFFF_8000_0000, 3'd4},
      '{32'h41F0D093, 64'h1000, 64'h0000_0000_0000_001F, 3'd6}
   };

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Immediates rebuilt with signed integer arithmetic on instruction fields.
   function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] pc, input int xl);
      longint      sx   = longint'($signed(ins));
      longint      imm  = 0;
      logic [2:0]  fmt  = 3'd7;
      logic [63:0] mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
      logic [6:0]  op   = ins[6:0];
      logic [2:0]  f3   = ins[14:12];
      exp_t        e;
      if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
         fmt = 3'd6;
         imm = (xl == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
      end else begin
         case (op)
            7'h03, 7'h13, 7'h67, 7'h73: begin fmt = 3'd1; imm = sx >>> 20; end
            7'h23: begin
               fmt = 3'd2;
               imm = (sx >>> 25) * 32 + longint'(ins[11:7]);
            end
            7'h63: begin
               fmt = 3'd3;
               imm = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048 +
                     longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h37, 7'h17: begin fmt = 3'd4; imm = (sx >>> 12) * 4096; end
            7'h6F: begin
               fmt = 3'd5;
               imm = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 +
                     longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h33, 7'h3B: begin fmt = 3'd0; imm = 0; end
            default:      begin fmt = 3'd7; imm = 0; end
         endcase
      end
      e.imm = 64'(imm) & mask;
      e.fmt = fmt;
      e.tgt = (pc + 64'(imm)) & mask;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h33, 7'h3B, 7'h1B, 7'h13};
      logic [31:0] w = $urandom;
      int          k = $urandom_range(0, 13);
      if (k < 13) w[6:0] = ops[k];
      return w;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int XL = (gi == 0) ? 32 : 64;
      localparam int DP = (gi == 0) ? 2 : 4;
      localparam logic [63:0] MASK = (XL == 32) ? 64'h0000_0000_FFFF_FFFF : '1;

      logic          rst_n     = 1'b0;
      logic          flush     = 1'b0;
      logic          in_valid  = 1'b0;
      logic          out_ready = 1'b0;
      logic [31:0]   instr     = '0;
      logic [XL-1:0] pc        = '0;
      logic          in_ready;
      logic          out_valid;
      logic [XL-1:0] imm;
      logic [XL-1:0] tgt;
      logic [2:0]    fmt;

      logic use_const = 1'b0;
      exp_t next_exp  = '0;
      exp_t sb [$];
      exp_t last = '0;
      exp_t head;
      int   pops = 0;
      bit   done = 1'b0;

      imm_gen_pipe #(.XLEN(XL), .DEPTH(DP)) u_dut (
         .clk_i       (clk),
         .rst_n_i     (rst_n),
         .flush_i     (flush),
         .in_valid_i  (in_valid),
         .in_ready_o  (in_ready),
         .instr_i     (instr),
         .pc_i        (pc),
         .out_valid_o (out_valid),
         .out_ready_i (out_ready),
         .imm_o       (imm),
         .fmt_o       (fmt),
         .target_o    (tgt)
      );

      task automatic c(input string name, input logic [63:0] act, input logic [63:0] exp);
         chk($sformatf("x%0d_%s", XL, name), act, exp);
      endtask

      task automatic cyc();
         @(posedge clk);
         #1;
      endtask

      function automatic logic [XL-1:0] rand_pc();
         logic [63:0] r = {$urandom, $urandom};
         return r[XL-1:0];
      endfunction

      // Monitor: pop-and-compare on every output handshake, push on accept.
      always @(negedge clk) begin
         if (!rst_n) begin
            sb.delete();
            last = '0;
         end else begin
            c("valid", 64'(out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
               last = sb[0];
            end else begin
               c("hold_imm", 64'(imm), last.imm);
               c("hold_fmt", 64'(fmt), 64'(last.fmt));
               c("hold_tgt", 64'(tgt), last.tgt);
            end
            if (flush) begin
               sb.delete();
            end else begin
               if (out_valid && out_ready && sb.size() != 0) begin
                  head = sb.pop_front();
                  pops++;
                  c("imm", 64'(imm), head.imm);
                  c("fmt", 64'(fmt), 64'(head.fmt));
                  c("tgt", 64'(tgt), head.tgt);
               end
               if (in_valid && in_ready)
                  sb.push_back(use_const ? next_exp : ref_model(instr, 64'(pc), XL));
            end
         end
      end

      task automatic offer(input logic [31:0] ins, input logic [XL-1:0] p,
                           input bit cst, input exp_t e);
         bit acc = 1'b0;
         instr     = ins;
         pc        = p;
         use_const = cst;
         next_exp  = e;
         in_valid  = 1'b1;
         for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
         end
         in_valid  = 1'b0;
         use_const = 1'b0;
         c("accept", 64'(acc), 64'd1);
      endtask

      task automatic drain();
         out_ready = 1'b1;
         for (int k = 0; k < 200 && sb.size() != 0; k++) cyc();
         c("drained", 64'(sb.size()), 64'd0);
         cyc();
      endtask

      initial begin
         exp_t e = '0;
         int   p0;
         repeat (3) cyc();
         c("rst_valid", 64'(out_valid), 64'd0);
         c("rst_ready", 64'(in_ready), 64'd0);
         c("rst_imm", 64'(imm), 64'd0);
         c("rst_fmt", 64'(fmt), 64'd0);
         c("rst_tgt", 64'(tgt), 64'd0);
         rst_n = 1'b1;
         c("ready_pre_edge", 64'(in_ready), 64'd0);
         cyc();
         c("ready_post_edge", 64'(in_ready), 64'd1);

         out_ready = 1'b1;
         foreach (vecs[i]) begin
            e.imm = vecs[i].imm & MASK;
            e.fmt = vecs[i].fmt;
            e.tgt = (vecs[i].pc + vecs[i].imm) & MASK;
            offer(vecs[i].instr, vecs[i].pc[XL-1:0], 1'b1, e);
         end
         drain();

         // Backpressure: fill, hold one more, then drain everything in order.
         out_ready = 1'b0;
         for (int i = 0; i < DP; i++) offer(rand_instr(), rand_pc(), 1'b0, e);
         c("full_ready", 64'(in_ready), 64'd0);
         instr    = rand_instr();
         pc       = rand_pc();
         in_valid = 1'b1;
         repeat (4) cyc();
         c("held_ready", 64'(in_ready), 64'd0);
         c("held_count", 64'(sb.size()), 64'(DP));
         p0        = pops;
         out_ready = 1'b1;
         offer(instr, pc, 1'b0, e);
         drain();
         c("drain_count", 64'(pops - p0), 64'(DP + 1));

         // Flush with two entries held and a new entry offered.
         out_ready = 1'b0;
         offer(rand_instr(), rand_pc(), 1'b0, e);
         offer(rand_instr(), rand_pc(), 1'b0, e);
         instr    = rand_instr();
         pc       = rand_pc();
         in_valid = 1'b1;
         flush    = 1'b1;
         cyc();
         flush    = 1'b0;
         in_valid = 1'b0;
         c("flush_valid", 64'(out_valid), 64'd0);
         c("flush_ready", 64'(in_ready), 64'd1);
         out_ready = 1'b1;
         repeat (3) cyc();
         c("flush_dropped", 64'(out_valid), 64'd0);

         for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            pc        = rand_pc();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cyc();
         end
         flush    = 1'b0;
         in_valid = 1'b0;
         drain();

         // Asynchronous reset in the middle of a drain.
         out_ready = 1'b0;
         offer(rand_instr(), rand_pc(), 1'b0, e);
         offer(rand_instr(), rand_pc(), 1'b0, e);
         out_ready = 1'b1;
         cyc();
         #2 rst_n = 1'b0;
         #1;
         c("arst_valid", 64'(out_valid), 64'd0);
         c("arst_ready", 64'(in_ready), 64'd0);
         c("arst_imm", 64'(imm), 64'd0);
         c("arst_fmt", 64'(fmt), 64'd0);
         c("arst_tgt", 64'(tgt), 64'd0);
         cyc();
         cyc();
         rst_n = 1'b1;
         cyc();
         c("rerst_ready", 64'(in_ready), 64'd1);
         c("rerst_valid", 64'(out_valid), 64'd0);
         repeat (2) cyc();
         done = 1'b1;
      end
   end

   initial begin
      for (int k = 0; k < 40000 && !(g_dut[0].done && g_dut[1].done); k++) @(posedge clk);
      chk("bench_complete", 64'(g_dut[0].done && g_dut[1].done), 64'd1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate, PC and target; legal values 32 and 64 only.
REQ-002 Parameter DEPTH, default 2, number of output buffer entries; legal values are 2 to 8.
REQ-003 clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid_i  input  1  the upstream stage offers instr_i and pc_i.
REQ-007 in_ready_o  output  1  the block accepts an entry this cycle.
REQ-008 instr_i  input  32  raw RV instruction word.
REQ-009 pc_i  input  XLEN  address of the instruction.
REQ-010 out_valid_o  output  1  the head buffer entry is valid.
REQ-011 out_ready_i  input  1  the downstream stage consumes the head entry.
REQ-012 imm_o  output  XLEN  decoded, extended immediate.
REQ-013 fmt_o  output  3  immediate format code, as defined in REQ-017.
REQ-014 target_o  output  XLEN  pc + imm, for the branch and jump pipeline.

Function
REQ-015 An entry SHALL be accepted when in_valid_i and in_ready_o are both high; in_ready_o SHALL be the registered value of "buffer not full".
REQ-016 Decode and extension SHALL complete in the accept cycle; an accepted entry SHALL appear at the outputs no earlier than the next cycle (latency 1).
REQ-017 Format select by instr_i[6:0]:
  - I (code 1): 0000011, 0010011, 1100111, 1110011
  - S (code 2): 0100011
  - B (code 3): 1100011
  - U (code 4): 0110111, 0010111
  - J (code 5): 1101111
  - R (code 0): 0110011, 0111011; imm = 0
  - any other opcode: ILL (code 7), imm = 0
REQ-018 I-shift override, code 6: opcode 0010011 or 0011011 with funct3 001 or 101.
  - imm is the zero-extended shamt.
  - shamt is instr_i[24:20] when XLEN=32, instr_i[25:20] when XLEN=64.
  - funct7 bits are excluded from imm.
REQ-019 S, B, I, U and J immediates SHALL be sign-extended from instr_i[31] to XLEN.
  - U immediate = instr_i[31:12] followed by 12 zero bits.
  - B and J immediates have bit 0 forced to 0.
REQ-020 target_o SHALL equal pc + imm modulo 2^XLEN, for every format.
REQ-021 The buffer SHALL be FIFO-ordered.
  - An entry is popped when out_valid_o and out_ready_i are both high.
  - A push and a pop in the same cycle when full SHALL NOT be accepted, because in_ready_o is registered low.
  - A push and a pop in the same cycle otherwise leave occupancy unchanged.
REQ-022 When empty, out_valid_o SHALL be 0 and imm_o, fmt_o and target_o SHALL hold their last values.
REQ-023 flush_i SHALL empty the buffer in the next cycle and take priority over a simultaneous push and pop; the flushed input is dropped.
REQ-024 The read and write pointers SHALL wrap modulo DEPTH.
  - The occupancy counter is $clog2(DEPTH+1) bits wide.
  - The occupancy counter never exceeds DEPTH.

Reset
REQ-025 While rst_n_i is low, all of these SHALL be 0 regardless of clock activity: out_valid_o, in_ready_o, imm_o, fmt_o, target_o, the pointers and the occupancy.
REQ-026 When rst_n_i is asserted mid-operation, all buffered entries SHALL be lost.
REQ-027 in_ready_o SHALL rise on the first clock edge after rst_n_i deasserts.

Structure
REQ-028 Package imm_gen_pkg SHALL hold:
  - the 3-bit format enum (R, I, S, B, U, J, ISH, ILL);
  - the opcode constants;
  - the legal-XLEN check function.
REQ-029 The combinational decoder SHALL be the single sub-module imm_decode (instr_i in, imm and fmt out, parametrised on XLEN); buffering, handshake and target addition SHALL live in imm_gen_pipe.

Verification
REQ-030 S-type: instr 0xFE112E23, pc 0x0 -> imm_o 0xFFFFFFFC, fmt_o 2, target_o 0xFFFFFFFC, all one cycle after accept.
REQ-031 B-type: instr 0xFE000CE3, pc 0x100 -> imm_o 0xFFFFFFF8, fmt_o 3, target_o 0x000000F8.
REQ-032 J-type wrap: instr 0xFFDFF06F, pc 0x0 -> imm_o 0xFFFFFFFC, target_o 0xFFFFFFFC.
REQ-033 XLEN=64, U-type: instr 0x800000B7 -> imm_o 0xFFFFFFFF80000000. I-shift: instr 0x41F0D093 -> imm_o 0x1F, fmt_o 6.
REQ-034 Backpressure (DEPTH=2): hold out_ready_i=0 and push 3 instructions.
  - in_ready_o is 0 after 2 accepts and the third is held.
  - Raising out_ready_i drains all three in order with no loss.
REQ-035 Flush and reset:
  - flush_i asserted with 2 entries held and in_valid_i=1 -> out_valid_o=0 next cycle, the new entry is dropped.
  - rst_n_i pulsed low mid-drain -> all outputs are 0 asynchronously.
